// File: rtl/csr_fetch_pkg.sv
// Shared types for the CSR stream fetcher: stream tags, FSM states and the
// round-robin successor function.
package csr_fetch_pkg;

  localparam int NUM_STREAMS = 3;

  typedef enum logic [1:0] {
    VAL = 2'd0,
    COL = 2'd1,
    LEN = 2'd2
  } stream_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Round-robin order val -> col -> len -> val.
  function automatic stream_e next_stream(input stream_e s);
    case (s)
      VAL:     return COL;
      COL:     return LEN;
      default: return VAL;
    endcase
  endfunction

endpackage

// File: rtl/csr_stream_fetcher_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output. The head
// word reads as zero whenever the FIFO is empty.
module sync_fifo_fwft #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              wr_fire, rd_fire;

  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign rd_data = valid ? mem[rd_ptr_q] : '0;
  assign rd_fire = rd_en && valid;
  assign wr_fire = wr_en && ((count_q != CW'(FIFO_DEPTH)) || rd_fire);

  // Pointer and occupancy update; simultaneous push and pop leave count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/csr_stream_fetcher.sv
// Fetches the values, column-index and row-length arrays of a CSR matrix from
// a shared single-port ROM into three FWFT FIFOs, one read per cycle, with
// round-robin arbitration between the streams.
module csr_stream_fetcher
  import csr_fetch_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int VAL_START  = 0,
  parameter int COL_START  = 3971,
  parameter int LEN_START  = 7942,
  parameter int NNZ        = 3971,
  parameter int ROWS       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] val_data,
  output logic [DATA_W-1:0] col_data,
  output logic [DATA_W-1:0] len_data,
  output logic              val_valid,
  output logic              col_valid,
  output logic              len_valid,
  input  logic              val_ready,
  input  logic              col_ready,
  input  logic              len_ready,
  output logic              busy,
  output logic              done
);

  localparam int MAXC   = (NNZ > ROWS) ? NNZ : ROWS;
  localparam int CNT_W  = $clog2(MAXC + 1) + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCNT_W:0] DEPTH_L = (FCNT_W + 1)'(FIFO_DEPTH);

  function automatic logic [ADDR_W-1:0] base_of(input int s);
    case (s)
      0:       return ADDR_W'(VAL_START);
      1:       return ADDR_W'(COL_START);
      default: return ADDR_W'(LEN_START);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] total_of(input int s);
    return (s == 2) ? CNT_W'(ROWS) : CNT_W'(NNZ);
  endfunction

  state_e                   state_q, state_d;
  stream_e                  last_q, last_d, rd_tag_q, rd_tag_d, gnt, cand;
  logic                     rd_vld_q, rd_vld_d, done_q, done_d, gnt_vld;
  logic                     all_issued, all_empty;
  logic [ADDR_W-1:0]        ptr_q [NUM_STREAMS];
  logic [ADDR_W-1:0]        ptr_d [NUM_STREAMS];
  logic [CNT_W-1:0]         cnt_q [NUM_STREAMS];
  logic [CNT_W-1:0]         cnt_d [NUM_STREAMS];
  logic [DATA_W-1:0]        f_data  [NUM_STREAMS];
  logic [FCNT_W-1:0]        f_count [NUM_STREAMS];
  logic [NUM_STREAMS-1:0]   f_valid, f_wr, f_rd, f_ready, elig;
  logic [FCNT_W:0]          occ;

  assign f_ready = {len_ready, col_ready, val_ready};

  for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_fifo
    assign f_wr[s] = rd_vld_q && (rd_tag_q == stream_e'(2'(s)));
    assign f_rd[s] = f_valid[s] && f_ready[s];
    sync_fifo_fwft #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (f_wr[s]),
      .wr_data (rom_data),
      .rd_en   (f_rd[s]),
      .rd_data (f_data[s]),
      .valid   (f_valid[s]),
      .count   (f_count[s])
    );
  end

  assign val_data  = f_data[0];
  assign col_data  = f_data[1];
  assign len_data  = f_data[2];
  assign val_valid = f_valid[0];
  assign col_valid = f_valid[1];
  assign len_valid = f_valid[2];
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rom_addr  = gnt_vld ? ptr_q[gnt] : '0;

  // Eligibility (space counts the returning read) and round-robin grant after last_q.
  always_comb begin
    elig       = '0;
    occ        = '0;
    gnt_vld    = 1'b0;
    gnt        = VAL;
    cand       = VAL;
    all_issued = 1'b1;
    all_empty  = 1'b1;
    for (int s = 0; s < NUM_STREAMS; s++) begin
      occ     = {1'b0, f_count[s]} + {{FCNT_W{1'b0}}, f_wr[s]};
      elig[s] = (cnt_q[s] != '0) && (occ < DEPTH_L);
      if (cnt_q[s] != '0) all_issued = 1'b0;
      if (f_valid[s])     all_empty  = 1'b0;
    end
    if (state_q == S_FETCH) begin
      cand = next_stream(last_q);
      for (int k = 0; k < NUM_STREAMS; k++) begin
        if (!gnt_vld && elig[cand]) begin
          gnt_vld = 1'b1;
          gnt     = cand;
        end
        cand = next_stream(cand);
      end
    end
  end

  // FSM next state, pointer/count bookkeeping and return-tag capture.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rd_vld_d = 1'b0;
    rd_tag_d = rd_tag_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          for (int s = 0; s < NUM_STREAMS; s++) begin
            ptr_d[s] = base_of(s);
            cnt_d[s] = total_of(s);
          end
        end
      end
      S_FETCH: begin
        if (gnt_vld) begin
          ptr_d[gnt] = ptr_q[gnt] + ADDR_W'(1);
          cnt_d[gnt] = cnt_q[gnt] - CNT_W'(1);
          last_d     = gnt;
          rd_vld_d   = 1'b1;
          rd_tag_d   = gnt;
        end
        if (all_issued && !rd_vld_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (all_empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered control state; reset drops any in-flight return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= LEN;
      rd_vld_q <= 1'b0;
      rd_tag_q <= VAL;
      done_q   <= 1'b0;
      for (int s = 0; s < NUM_STREAMS; s++) begin
        ptr_q[s] <= '0;
        cnt_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rd_vld_q <= rd_vld_d;
      rd_tag_q <= rd_tag_d;
      done_q   <= done_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
